// File: rtl/rob_fill_tx_if.sv
// Result lanes into the fill arbiter, and the fill command out to the ROB.
//   Lanes alu/mul/div: <lane>_valid, <lane>_idx, <lane>_data, <lane>_exc in; <lane>_ready out.
//   Fill: fill_valid, fill_idx, fill_data, fill_exc, fill_src out; fill_ready in.
//   master = producers plus ROB (bench side); slave = rob_fill_tx.
interface rob_fill_tx_if #(
  parameter int unsigned ROB_IDX_W = 5,
  parameter int unsigned DATA_W    = 32
);
  logic                 alu_valid;
  logic                 alu_ready;
  logic [ROB_IDX_W-1:0] alu_idx;
  logic [DATA_W-1:0]    alu_data;
  logic                 alu_exc;

  logic                 mul_valid;
  logic                 mul_ready;
  logic [ROB_IDX_W-1:0] mul_idx;
  logic [DATA_W-1:0]    mul_data;
  logic                 mul_exc;

  logic                 div_valid;
  logic                 div_ready;
  logic [ROB_IDX_W-1:0] div_idx;
  logic [DATA_W-1:0]    div_data;
  logic                 div_exc;

  logic                 fill_valid;
  logic                 fill_ready;
  logic [ROB_IDX_W-1:0] fill_idx;
  logic [DATA_W-1:0]    fill_data;
  logic                 fill_exc;
  logic [1:0]           fill_src;

  modport master (
    output alu_valid, alu_idx, alu_data, alu_exc,
    output mul_valid, mul_idx, mul_data, mul_exc,
    output div_valid, div_idx, div_data, div_exc,
    output fill_ready,
    input  alu_ready, mul_ready, div_ready,
    input  fill_valid, fill_idx, fill_data, fill_exc, fill_src
  );

  modport slave (
    input  alu_valid, alu_idx, alu_data, alu_exc,
    input  mul_valid, mul_idx, mul_data, mul_exc,
    input  div_valid, div_idx, div_data, div_exc,
    input  fill_ready,
    output alu_ready, mul_ready, div_ready,
    output fill_valid, fill_idx, fill_data, fill_exc, fill_src
  );
endinterface

// File: rtl/rob_fill_tx.sv
// Merges alu/mul/div execution results into one ROB fill port.
// Each lane has a 2-entry FIFO; a round-robin arbiter feeds a single
// registered output stage (2-cycle minimum latency, 1 fill/cycle sustained).
//   clk, rst_n  : clock, async active-low reset
//   flush       : drops every held entry and this cycle's pushes/acceptance
//   busy        : output stage or any FIFO holds an entry
//   fill_count  : wrapping count of accepted fills (survives flush)
//   bus         : lane and fill handshakes (rob_fill_tx_if.slave)
module rob_fill_tx #(
  parameter int unsigned ROB_IDX_W = 5,
  parameter int unsigned DATA_W    = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  output logic        busy,
  output logic [15:0] fill_count,
  rob_fill_tx_if.slave bus
);

  localparam int unsigned NLANES  = 3;
  localparam int unsigned DEPTH   = 2;
  localparam int unsigned CNT_W   = 2;
  localparam int unsigned COUNT_W = 16;

  typedef struct packed {
    logic [ROB_IDX_W-1:0] idx;
    logic [DATA_W-1:0]    data;
    logic                 exc;
  } entry_t;

  // Lane FIFO state
  entry_t           mem_q   [NLANES][DEPTH];
  entry_t           mem_d   [NLANES][DEPTH];
  logic [CNT_W-1:0] cnt_q   [NLANES];
  logic [CNT_W-1:0] cnt_d   [NLANES];
  logic             wr_ptr_q[NLANES];
  logic             wr_ptr_d[NLANES];
  logic             rd_ptr_q[NLANES];
  logic             rd_ptr_d[NLANES];

  // Output stage and arbitration state
  logic               out_valid_q, out_valid_d;
  entry_t             out_q, out_d;
  logic [1:0]         out_src_q, out_src_d;
  logic [1:0]         last_grant_q, last_grant_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic               ready_en_q;

  logic   lane_valid_c[NLANES];
  entry_t lane_in_c   [NLANES];
  logic   lane_ready_c[NLANES];
  logic   push_c      [NLANES];
  logic   load_c;
  logic   accept_c;
  logic   grant_valid_c;
  logic [1:0] grant_c;

  function automatic logic [1:0] next_lane(input logic [1:0] l);
    return (l == 2'd2) ? 2'd0 : l + 2'd1;
  endfunction

  // Gather lane inputs into arrays
  always_comb begin
    lane_valid_c[0] = bus.alu_valid;
    lane_valid_c[1] = bus.mul_valid;
    lane_valid_c[2] = bus.div_valid;
    lane_in_c[0]    = entry_t'{idx: bus.alu_idx, data: bus.alu_data, exc: bus.alu_exc};
    lane_in_c[1]    = entry_t'{idx: bus.mul_idx, data: bus.mul_data, exc: bus.mul_exc};
    lane_in_c[2]    = entry_t'{idx: bus.div_idx, data: bus.div_data, exc: bus.div_exc};
  end

  // Ready depends only on local state and flush, never on fill_ready or valids
  always_comb begin
    for (int i = 0; i < NLANES; i++) begin
      lane_ready_c[i] = ready_en_q && (cnt_q[i] != CNT_W'(DEPTH)) && !flush;
      push_c[i]       = lane_valid_c[i] && lane_ready_c[i];
    end
  end

  assign bus.alu_ready = lane_ready_c[0];
  assign bus.mul_ready = lane_ready_c[1];
  assign bus.div_ready = lane_ready_c[2];

  assign load_c   = !out_valid_q || bus.fill_ready;
  assign accept_c = out_valid_q && bus.fill_ready && !flush;

  // Round-robin pick starting one past the last granted lane
  always_comb begin
    logic [1:0] cand;
    grant_valid_c = 1'b0;
    grant_c       = last_grant_q;
    cand          = next_lane(last_grant_q);
    for (int k = 0; k < NLANES; k++) begin
      if (!grant_valid_c && (cnt_q[cand] != '0)) begin
        grant_valid_c = 1'b1;
        grant_c       = cand;
      end
      cand = next_lane(cand);
    end
  end

  // FIFO, output stage and counter next-state
  always_comb begin
    mem_d        = mem_q;
    cnt_d        = cnt_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    out_valid_d  = out_valid_q;
    out_d        = out_q;
    out_src_d    = out_src_q;
    last_grant_d = last_grant_q;
    count_d      = count_q + COUNT_W'(accept_c);

    for (int i = 0; i < NLANES; i++) begin
      logic pop;
      pop = load_c && grant_valid_c && (grant_c == 2'(i)) && !flush;
      if (flush) begin
        cnt_d[i]    = '0;
        wr_ptr_d[i] = 1'b0;
        rd_ptr_d[i] = 1'b0;
      end else begin
        if (push_c[i]) begin
          mem_d[i][wr_ptr_q[i]] = lane_in_c[i];
          wr_ptr_d[i]           = ~wr_ptr_q[i];
        end
        if (pop) begin
          rd_ptr_d[i] = ~rd_ptr_q[i];
        end
        cnt_d[i] = cnt_q[i] + CNT_W'(push_c[i]) - CNT_W'(pop);
      end
    end

    if (flush) begin
      out_valid_d = 1'b0;
    end else if (load_c) begin
      out_valid_d = grant_valid_c;
      if (grant_valid_c) begin
        out_d        = mem_q[grant_c][rd_ptr_q[grant_c]];
        out_src_d    = grant_c;
        last_grant_d = grant_c;
      end
    end
  end

  // State registers; reset leaves last_grant at div so alu wins first
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NLANES; i++) begin
        for (int j = 0; j < DEPTH; j++) begin
          mem_q[i][j] <= '0;
        end
        cnt_q[i]    <= '0;
        wr_ptr_q[i] <= 1'b0;
        rd_ptr_q[i] <= 1'b0;
      end
      out_valid_q  <= 1'b0;
      out_q        <= '0;
      out_src_q    <= '0;
      last_grant_q <= 2'd2;
      count_q      <= '0;
      ready_en_q   <= 1'b0;
    end else begin
      mem_q        <= mem_d;
      cnt_q        <= cnt_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      out_valid_q  <= out_valid_d;
      out_q        <= out_d;
      out_src_q    <= out_src_d;
      last_grant_q <= last_grant_d;
      count_q      <= count_d;
      ready_en_q   <= 1'b1;
    end
  end

  assign bus.fill_valid = out_valid_q;
  assign bus.fill_idx   = out_q.idx;
  assign bus.fill_data  = out_q.data;
  assign bus.fill_exc   = out_q.exc;
  assign bus.fill_src   = out_src_q;
  assign fill_count     = count_q;
  assign busy           = out_valid_q || (cnt_q[0] != '0) || (cnt_q[1] != '0) || (cnt_q[2] != '0);

endmodule

// File: tb/tb_rob_fill_tx.sv
// Directed bench for rob_fill_tx: ordering, backpressure, flush, counter wrap, async reset.
module tb_rob_fill_tx;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        busy;
  logic [15:0] fill_count;

  int n_cmp = 0;
  int n_err = 0;
  int n_steps;

  rob_fill_tx_if #(.ROB_IDX_W(5), .DATA_W(32)) bus ();

  rob_fill_tx #(.ROB_IDX_W(5), .DATA_W(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .busy       (busy),
    .fill_count (fill_count),
    .bus        (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    flush = 1'b0;
    bus.fill_ready = 1'b0;
    bus.alu_valid = 1'b0; bus.alu_idx = '0; bus.alu_data = '0; bus.alu_exc = 1'b0;
    bus.mul_valid = 1'b0; bus.mul_idx = '0; bus.mul_data = '0; bus.mul_exc = 1'b0;
    bus.div_valid = 1'b0; bus.div_idx = '0; bus.div_data = '0; bus.div_exc = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #2;
    check("rst_fill_valid", 64'(bus.fill_valid), 64'd0);
    check("rst_fill_idx",   64'(bus.fill_idx),   64'd0);
    check("rst_fill_data",  64'(bus.fill_data),  64'd0);
    check("rst_fill_src",   64'(bus.fill_src),   64'd0);
    check("rst_busy",       64'(busy),           64'd0);
    check("rst_count",      64'(fill_count),     64'd0);
    check("rst_alu_ready",  64'(bus.alu_ready),  64'd0);
    check("rst_div_ready",  64'(bus.div_ready),  64'd0);
    rst_n = 1'b1;
    #1;
    check("rel_ready_before_edge", 64'(bus.mul_ready), 64'd0);
    step();
    check("rel_alu_ready", 64'(bus.alu_ready), 64'd1);
    check("rel_mul_ready", 64'(bus.mul_ready), 64'd1);
    check("rel_div_ready", 64'(bus.div_ready), 64'd1);

    // Three lanes at once: src 0,1,2 on consecutive cycles
    bus.fill_ready = 1'b1;
    bus.alu_valid = 1'b1; bus.alu_idx = 5'd1; bus.alu_data = 32'h1111_1111;
    bus.mul_valid = 1'b1; bus.mul_idx = 5'd2; bus.mul_data = 32'h2222_2222;
    bus.div_valid = 1'b1; bus.div_idx = 5'd3; bus.div_data = 32'h3333_3333; bus.div_exc = 1'b1;
    step();
    bus.alu_valid = 1'b0; bus.mul_valid = 1'b0; bus.div_valid = 1'b0; bus.div_exc = 1'b0;
    check("tri_nobypass", 64'(bus.fill_valid), 64'd0);
    check("tri_busy",     64'(busy),           64'd1);
    step();
    check("tri0_valid", 64'(bus.fill_valid), 64'd1);
    check("tri0_src",   64'(bus.fill_src),   64'd0);
    check("tri0_idx",   64'(bus.fill_idx),   64'd1);
    check("tri0_data",  64'(bus.fill_data),  64'h1111_1111);
    step();
    check("tri1_src",   64'(bus.fill_src),   64'd1);
    check("tri1_idx",   64'(bus.fill_idx),   64'd2);
    check("tri1_count", 64'(fill_count),     64'd1);
    step();
    check("tri2_src",   64'(bus.fill_src),   64'd2);
    check("tri2_idx",   64'(bus.fill_idx),   64'd3);
    check("tri2_exc",   64'(bus.fill_exc),   64'd1);
    step();
    check("tri_end_valid", 64'(bus.fill_valid), 64'd0);
    check("tri_end_count", 64'(fill_count),     64'd3);
    check("tri_end_busy",  64'(busy),           64'd0);

    // Single alu push, two-cycle latency
    bus.alu_valid = 1'b1; bus.alu_idx = 5'd5; bus.alu_data = 32'hDEAD_BEEF;
    step();
    bus.alu_valid = 1'b0;
    check("one_latency", 64'(bus.fill_valid), 64'd0);
    step();
    check("one_valid", 64'(bus.fill_valid), 64'd1);
    check("one_idx",   64'(bus.fill_idx),   64'd5);
    check("one_data",  64'(bus.fill_data),  64'hDEAD_BEEF);
    check("one_src",   64'(bus.fill_src),   64'd0);
    step();
    check("one_count", 64'(fill_count),     64'd4);
    check("one_done",  64'(bus.fill_valid), 64'd0);

    // Backpressure: mul pushes 3 while fill_ready=0
    bus.fill_ready = 1'b0;
    bus.mul_valid = 1'b1; bus.mul_idx = 5'd1; bus.mul_data = 32'hA1;
    step();
    bus.mul_idx = 5'd2; bus.mul_data = 32'hA2;
    step();
    bus.mul_idx = 5'd3; bus.mul_data = 32'hA3;
    step();
    bus.mul_valid = 1'b0;
    check("bp_mul_ready", 64'(bus.mul_ready),  64'd0);
    check("bp_valid",     64'(bus.fill_valid), 64'd1);
    check("bp_idx",       64'(bus.fill_idx),   64'd1);
    check("bp_src",       64'(bus.fill_src),   64'd1);
    step();
    step();
    check("bp_hold_idx",   64'(bus.fill_idx),  64'd1);
    check("bp_hold_data",  64'(bus.fill_data), 64'hA1);
    check("bp_hold_count", 64'(fill_count),    64'd4);
    check("bp_hold_ready", 64'(bus.mul_ready), 64'd0);
    bus.fill_ready = 1'b1;
    step();
    check("bp_d2_idx",   64'(bus.fill_idx), 64'd2);
    check("bp_d2_count", 64'(fill_count),   64'd5);
    step();
    check("bp_d3_idx",   64'(bus.fill_idx),  64'd3);
    check("bp_d3_data",  64'(bus.fill_data), 64'hA3);
    check("bp_d3_count", 64'(fill_count),    64'd6);
    step();
    check("bp_end_valid", 64'(bus.fill_valid), 64'd0);
    check("bp_end_count", 64'(fill_count),     64'd7);
    check("bp_end_busy",  64'(busy),           64'd0);

    // Flush with four entries held (last grant was mul, so div wins next)
    bus.fill_ready = 1'b0;
    bus.alu_valid = 1'b1; bus.alu_idx = 5'd10;
    bus.mul_valid = 1'b1; bus.mul_idx = 5'd11;
    bus.div_valid = 1'b1; bus.div_idx = 5'd12;
    step();
    bus.alu_idx = 5'd13; bus.mul_valid = 1'b0; bus.div_valid = 1'b0;
    step();
    bus.alu_valid = 1'b0;
    check("fl_pre_valid", 64'(bus.fill_valid), 64'd1);
    check("fl_pre_src",   64'(bus.fill_src),   64'd2);
    check("fl_pre_idx",   64'(bus.fill_idx),   64'd12);
    check("fl_pre_alu_full", 64'(bus.alu_ready), 64'd0);
    flush = 1'b1;
    bus.fill_ready = 1'b1;
    bus.div_valid = 1'b1; bus.div_idx = 5'd14;
    #1;
    check("fl_div_ready", 64'(bus.div_ready), 64'd0);
    step();
    flush = 1'b0;
    bus.div_valid = 1'b0;
    check("fl_busy",  64'(busy),           64'd0);
    check("fl_valid", 64'(bus.fill_valid), 64'd0);
    check("fl_count", 64'(fill_count),     64'd7);
    step();
    check("fl_drop_valid", 64'(bus.fill_valid), 64'd0);
    check("fl_drop_busy",  64'(busy),           64'd0);

    // Last grant (div) survives flush: alu goes before mul
    bus.alu_valid = 1'b1; bus.alu_idx = 5'd20;
    bus.mul_valid = 1'b1; bus.mul_idx = 5'd21;
    step();
    bus.alu_valid = 1'b0; bus.mul_valid = 1'b0;
    step();
    check("lg_first_src", 64'(bus.fill_src), 64'd0);
    check("lg_first_idx", 64'(bus.fill_idx), 64'd20);
    step();
    check("lg_second_src", 64'(bus.fill_src), 64'd1);
    step();
    check("lg_count", 64'(fill_count), 64'd9);
    check("lg_busy",  64'(busy),       64'd0);

    // Counter wrap: stream alu results at one fill per cycle up to 0xFFFF
    bus.alu_valid = 1'b1; bus.alu_idx = 5'd30; bus.alu_data = 32'h5A5A_5A5A;
    n_steps = 0;
    while (fill_count != 16'hFFFF && n_steps < 70000) begin
      step();
      n_steps++;
    end
    bus.alu_valid = 1'b0;
    bus.fill_ready = 1'b0;
    check("wrap_reach",      64'(fill_count), 64'hFFFF);
    check("wrap_throughput", 64'(n_steps),    64'd65528);
    bus.fill_ready = 1'b1;
    step();
    check("wrap_zero",  64'(fill_count),     64'h0000);
    check("wrap_valid", 64'(bus.fill_valid), 64'd1);
    step();
    check("wrap_one",  64'(fill_count), 64'd1);
    check("wrap_idle", 64'(busy),       64'd0);

    // Async reset while a fill is pending
    bus.fill_ready = 1'b0;
    bus.alu_valid = 1'b1; bus.alu_idx = 5'd7;
    step();
    bus.alu_valid = 1'b0;
    step();
    check("ar_pre_valid", 64'(bus.fill_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    check("ar_valid",     64'(bus.fill_valid), 64'd0);
    check("ar_alu_ready", 64'(bus.alu_ready),  64'd0);
    check("ar_mul_ready", 64'(bus.mul_ready),  64'd0);
    check("ar_div_ready", 64'(bus.div_ready),  64'd0);
    check("ar_busy",      64'(busy),           64'd0);
    check("ar_count",     64'(fill_count),     64'd0);
    #1;
    rst_n = 1'b1;
    step();
    bus.fill_ready = 1'b1;
    bus.alu_valid = 1'b1; bus.alu_idx = 5'd8;
    bus.div_valid = 1'b1; bus.div_idx = 5'd9;
    step();
    bus.alu_valid = 1'b0; bus.div_valid = 1'b0;
    step();
    check("ar_first_src", 64'(bus.fill_src), 64'd0);
    check("ar_first_idx", 64'(bus.fill_idx), 64'd8);
    step();
    check("ar_second_src", 64'(bus.fill_src), 64'd2);
    step();
    check("ar_end_busy",  64'(busy),       64'd0);
    check("ar_end_count", 64'(fill_count), 64'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
